// File: rtl/tone_gen_pkg.sv
// Shared types and constants for the tone generator control path.
package tone_gen_pkg;

  localparam int MASTER_W = 10;

  // Upper master-count bits that mark the 16-cycle slot processing window.
  localparam logic [5:0] PROC_WINDOW_ID = 6'h00;

  // Datapath register map bases.
  localparam logic [4:0] ADDR_INCR = 5'h00;
  localparam logic [4:0] ADDR_VOL  = 5'h04;
  localparam logic [4:0] ADDR_WAVE = 5'h08;
  localparam logic [4:0] ADDR_LUT  = 5'h10;

  typedef struct packed {
    logic [4:0]  addr;
    logic [15:0] data;
  } reg_wr_t;

  // True when a write registered at this count lands outside the processing window.
  // The last count of the frame is excluded because the registered output would
  // then reach the datapath at count 0.
  function automatic logic window_clear(input logic [MASTER_W-1:0] cnt);
    return (cnt[MASTER_W-1:4] != PROC_WINDOW_ID) && (cnt != {MASTER_W{1'b1}});
  endfunction

endpackage

// File: rtl/reg_wr_fifo.sv
// Synchronous FIFO of pending host register writes; extra pointer MSB separates full from empty.
module reg_wr_fifo
  import tone_gen_pkg::*;
#(
  parameter int  DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           push,
  input  reg_wr_t        push_data,
  input  logic           pop,
  output reg_wr_t        head,
  output logic           full,
  output logic           empty,
  output logic [PTR_W:0] count
);

  reg_wr_t          mem [DEPTH];
  logic [PTR_W:0]   wptr;
  logic [PTR_W:0]   rptr;
  logic             push_ok;
  logic             pop_ok;

  // A push while full is refused; a same-cycle pop does not make room until the next cycle.
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  assign empty = (wptr == rptr);
  assign full  = (wptr[PTR_W] != rptr[PTR_W]) &&
                 (wptr[PTR_W-1:0] == rptr[PTR_W-1:0]);
  assign count = wptr - rptr;
  assign head  = mem[rptr[PTR_W-1:0]];

  // Pointer state; reset discards every queued entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push_ok) wptr <= wptr + 1'b1;
      if (pop_ok)  rptr <= rptr + 1'b1;
    end
  end

  // Entry storage needs no reset; only pointer-covered slots are ever read out.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wptr[PTR_W-1:0]] <= push_data;
  end

endmodule

// File: rtl/tone_reg_scheduler.sv
// Master count generator plus windowed release of queued host register writes.
module tone_reg_scheduler
  import tone_gen_pkg::*;
#(
  parameter int  DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic                clk_in,
  input  logic                reset_n_in,
  input  logic                wr_req_in,
  input  logic [4:0]          wr_addr_in,
  input  logic [15:0]         wr_data_in,
  output logic                wr_ready_out,
  input  logic                hold_in,
  output logic [MASTER_W-1:0] master_count_out,
  output logic [4:0]          reg_addr_out,
  output logic [15:0]         reg_data_out,
  output logic                reg_valid_out,
  output logic [PTR_W:0]      pending_out
);

  reg_wr_t   head;
  reg_wr_t   wr_entry;
  logic      full;
  logic      empty;
  logic      issue_ok;
  logic      issue;

  assign wr_entry = '{addr: wr_addr_in, data: wr_data_in};

  // Issue only outside the window (and its preceding cycle) unless the host is batching.
  assign issue_ok     = window_clear(master_count_out) && !hold_in;
  assign issue        = issue_ok && !empty;
  assign wr_ready_out = !full;

  reg_wr_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk_in),
    .rst_n     (reset_n_in),
    .push      (wr_req_in),
    .push_data (wr_entry),
    .pop       (issue_ok),
    .head      (head),
    .full      (full),
    .empty     (empty),
    .count     (pending_out)
  );

  // Free-running master count; natural wrap from all-ones back to zero.
  always_ff @(posedge clk_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      master_count_out <= '0;
    end else begin
      master_count_out <= master_count_out + 1'b1;
    end
  end

  // Register the popped head onto the datapath port; address/data hold between pulses.
  always_ff @(posedge clk_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      reg_valid_out <= 1'b0;
      reg_addr_out  <= '0;
      reg_data_out  <= '0;
    end else begin
      reg_valid_out <= issue;
      if (issue) begin
        reg_addr_out <= head.addr;
        reg_data_out <= head.data;
      end
    end
  end

endmodule

// File: tb/tb_tone_reg_scheduler.sv
// Directed bench for tone_reg_scheduler: window blocking, wrap guard, backpressure, ordering, reset.
module tb_tone_reg_scheduler;

  logic        clk_in;
  logic        reset_n_in;
  logic        wr_req_in;
  logic [4:0]  wr_addr_in;
  logic [15:0] wr_data_in;
  logic        wr_ready_out;
  logic        hold_in;
  logic [9:0]  master_count_out;
  logic [4:0]  reg_addr_out;
  logic [15:0] reg_data_out;
  logic        reg_valid_out;
  logic [2:0]  pending_out;

  int n_checks = 0;
  int n_errors = 0;
  int window_viol = 0;
  logic [20:0] pulses[$];

  tone_reg_scheduler #(.DEPTH(4)) dut (
    .clk_in           (clk_in),
    .reset_n_in       (reset_n_in),
    .wr_req_in        (wr_req_in),
    .wr_addr_in       (wr_addr_in),
    .wr_data_in       (wr_data_in),
    .wr_ready_out     (wr_ready_out),
    .hold_in          (hold_in),
    .master_count_out (master_count_out),
    .reg_addr_out     (reg_addr_out),
    .reg_data_out     (reg_data_out),
    .reg_valid_out    (reg_valid_out),
    .pending_out      (pending_out)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t count=%0d)", tag, got, exp, $time, master_count_out);
    end
  endtask

  // Record every pulse and flag any pulse seen during counts 0..15.
  always @(negedge clk_in) begin
    if (reset_n_in && reg_valid_out) begin
      pulses.push_back({reg_addr_out, reg_data_out});
      if (master_count_out <= 10'd15) window_viol++;
    end
  end

  // Advance to the next negedge at which the count equals n.
  task automatic wait_count(input logic [9:0] n);
    int guard = 0;
    do begin
      @(negedge clk_in);
      guard++;
    end while (master_count_out != n && guard < 2100);
    if (master_count_out != n) check("wait_count_timeout", 32'(master_count_out), 32'(n));
  endtask

  // Present a write and hold it until accepted; returns at the negedge after acceptance.
  task automatic push(input logic [4:0] a, input logic [15:0] d);
    int guard = 0;
    wr_req_in  = 1'b1;
    wr_addr_in = a;
    wr_data_in = d;
    while (!wr_ready_out && guard < 400) begin
      @(negedge clk_in);
      guard++;
    end
    if (!wr_ready_out) check("push_timeout", 32'(wr_ready_out), 32'd1);
    @(negedge clk_in);
    wr_req_in = 1'b0;
  endtask

  initial begin
    logic [20:0] exp_seq [8];
    reset_n_in = 1'b0;
    wr_req_in  = 1'b0;
    wr_addr_in = '0;
    wr_data_in = '0;
    hold_in    = 1'b0;
    repeat (3) @(negedge clk_in);

    // Reset state
    check("rst_count",   32'(master_count_out), 32'd0);
    check("rst_pending", 32'(pending_out), 32'd0);
    check("rst_ready",   32'(wr_ready_out), 32'd1);
    check("rst_valid",   32'(reg_valid_out), 32'd0);
    check("rst_addr",    32'(reg_addr_out), 32'd0);
    check("rst_data",    32'(reg_data_out), 32'd0);
    reset_n_in = 1'b1;

    // Window blocking: accepted at count 10, released at count 16, visible at 17
    wait_count(10'd10);
    push(5'h01, 16'h1234);
    wait_count(10'd15);
    check("win_valid_15", 32'(reg_valid_out), 32'd0);
    @(negedge clk_in);
    check("win_valid_16", 32'(reg_valid_out), 32'd0);
    @(negedge clk_in);
    check("win_valid_17", 32'(reg_valid_out), 32'd1);
    check("win_addr_17",  32'(reg_addr_out), 32'h01);
    check("win_data_17",  32'(reg_data_out), 32'h1234);
    @(negedge clk_in);
    check("win_valid_18", 32'(reg_valid_out), 32'd0);

    // LUT passthrough outside the window: accepted at 200, pulse at 202
    wait_count(10'd200);
    push(5'h13, 16'h000A);
    check("lut_valid_201", 32'(reg_valid_out), 32'd0);
    @(negedge clk_in);
    check("lut_valid_202", 32'(reg_valid_out), 32'd1);
    check("lut_addr_202",  32'(reg_addr_out), 32'h13);
    check("lut_data_202",  32'(reg_data_out), 32'h000A);
    @(negedge clk_in);
    check("lut_valid_203", 32'(reg_valid_out), 32'd0);
    check("lut_addr_hold", 32'(reg_addr_out), 32'h13);

    // Reset mid-operation with two writes queued under hold
    wait_count(10'd298);
    hold_in = 1'b1;
    push(5'h0A, 16'hDEAD);
    push(5'h0B, 16'hBEEF);
    check("mid_pending_pre", 32'(pending_out), 32'd2);
    reset_n_in = 1'b0;
    #1;
    check("mid_rst_count",   32'(master_count_out), 32'd0);
    check("mid_rst_pending", 32'(pending_out), 32'd0);
    check("mid_rst_valid",   32'(reg_valid_out), 32'd0);
    check("mid_rst_ready",   32'(wr_ready_out), 32'd1);
    hold_in = 1'b0;
    pulses.delete();
    repeat (3) @(negedge clk_in);
    reset_n_in = 1'b1;
    wait_count(10'd40);
    check("mid_no_issue", 32'(pulses.size()), 32'd0);

    // Full/backpressure: four writes under hold, fifth held by host, release at 100
    wait_count(10'd50);
    hold_in = 1'b1;
    for (int i = 0; i < 4; i++) push(5'(i), 16'hA000 + 16'(i));
    check("full_pending", 32'(pending_out), 32'd4);
    check("full_ready",   32'(wr_ready_out), 32'd0);
    fork
      push(5'h04, 16'hA004);
    join_none
    wait_count(10'd100);
    check("full_hold_valid", 32'(reg_valid_out), 32'd0);
    hold_in = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_in);
      check("drain_valid", 32'(reg_valid_out), 32'd1);
      check("drain_addr",  32'(reg_addr_out), 32'(i));
      check("drain_data",  32'(reg_data_out), 32'hA000 + 32'(i));
    end
    @(negedge clk_in);
    check("drain_done_valid",   32'(reg_valid_out), 32'd0);
    check("drain_done_pending", 32'(pending_out), 32'd0);

    // Simultaneous push/pop: two queued in window, push every cycle while issuing
    wait_count(10'd5);
    pulses.delete();
    push(5'h02, 16'hB0F2);
    push(5'h03, 16'hB0F3);
    wait_count(10'd16);
    check("pp_pending_16", 32'(pending_out), 32'd2);
    for (int k = 0; k < 6; k++) begin
      wr_req_in  = 1'b1;
      wr_addr_in = 5'h04 + 5'(k);
      wr_data_in = 16'hB000 + 16'(k);
      @(negedge clk_in);
      check("pp_pending", 32'(pending_out), 32'd2);
    end
    wr_req_in = 1'b0;
    repeat (12) @(negedge clk_in);
    exp_seq[0] = {5'h02, 16'hB0F2};
    exp_seq[1] = {5'h03, 16'hB0F3};
    for (int k = 0; k < 6; k++) exp_seq[2+k] = {5'h04 + 5'(k), 16'hB000 + 16'(k)};
    check("pp_count", 32'(pulses.size()), 32'd8);
    for (int k = 0; k < 8 && k < pulses.size(); k++)
      check("pp_order", 32'(pulses[k]), 32'(exp_seq[k]));

    // Wrap guard: head issued at 1022, second write (accepted at 1022) waits for next frame
    wait_count(10'd1021);
    push(5'h05, 16'h5A5A);
    push(5'h06, 16'h6B6B);
    check("wrap_valid_1023",   32'(reg_valid_out), 32'd1);
    check("wrap_addr_1023",    32'(reg_addr_out), 32'h05);
    check("wrap_data_1023",    32'(reg_data_out), 32'h5A5A);
    check("wrap_pending_1023", 32'(pending_out), 32'd1);
    @(negedge clk_in);
    check("wrap_count_0", 32'(master_count_out), 32'd0);
    check("wrap_valid_0", 32'(reg_valid_out), 32'd0);
    wait_count(10'd16);
    check("wrap_valid_16", 32'(reg_valid_out), 32'd0);
    @(negedge clk_in);
    check("wrap_valid_17", 32'(reg_valid_out), 32'd1);
    check("wrap_addr_17",  32'(reg_addr_out), 32'h06);
    check("wrap_data_17",  32'(reg_data_out), 32'h6B6B);

    check("window_violations", 32'(window_viol), 32'd0);
    check("end_pending", 32'(pending_out), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/tone_reg_scheduler.md
Name: tone_reg_scheduler

Overview:
- Owns the tone generator's timing and configuration write port.
- Generates the free-running 10-bit master count that sequences the 4-slot DDS/mixing datapath.
- Queues host register writes in a small FIFO and releases them only outside the processing window (master_id == 0) and the cycle before it, so phase increment, volume, wave type and wave-LUT updates never land while a slot is in progress.
- Sits between the host/bus bridge and the tone datapath.

Parameters:
- DEPTH, 4, write FIFO entries; must be a power of two and at least 2.
- PTR_W, $clog2(DEPTH), FIFO pointer width; derived, not overridden.

Ports:
- clk_in  input  1  system clock
- reset_n_in  input  1  asynchronous, active-low reset
- wr_req_in  input  1  host write request (valid)
- wr_addr_in  input  5  host register address; same map as datapath addr_in
- wr_data_in  input  16  host write data
- wr_ready_out  output  1  FIFO can accept; transfer occurs when wr_req_in && wr_ready_out
- hold_in  input  1  when 1, suppress issue so a batch can be released atomically
- master_count_out  output  10  master count to datapath
- reg_addr_out  output  5  datapath addr_in
- reg_data_out  output  16  datapath data_in
- reg_valid_out  output  1  datapath data_valid_in, one-cycle pulse per write
- pending_out  output  PTR_W+1  number of queued writes

Behaviour:
- Reset (async assert, sync release): master_count_out=0, FIFO empty, pending_out=0, wr_ready_out=1, reg_valid_out=0, reg_addr_out=0, reg_data_out=0. Reset mid-operation discards queued writes; no partial write is issued.
- Master count: +1 every clock, wraps 10'h3FF -> 10'h000. No enable.
- Issue window:
  - issue_ok = (master_count_out[9:4] != 0) && (master_count_out != 10'h3FF) && !hold_in.
  - Counts 0..15 are the processing window. Count 1023 is excluded because outputs are registered, so a write issued there would reach the datapath at count 0.
- Issue:
  - When issue_ok && !empty, pop the head and register it onto reg_addr_out/reg_data_out with reg_valid_out=1 on the next edge.
  - Otherwise reg_valid_out=0 on the next edge.
  - One write per clock; back-to-back pulses are allowed.
  - reg_addr_out/reg_data_out hold their last value when not valid.
- Latency: a write accepted into an empty FIFO at count c (issue_ok true at c+1) appears on reg_valid_out at edge c+2.
- Ordering: strict FIFO. No coalescing or reordering, including the wave-LUT range (addr[4]=1).
- FIFO handshake:
  - wr_ready_out = !full, registered state, no combinational path from wr_req_in.
  - Full: ready=0. A request while full is not accepted; the host holds it. A same-cycle pop does not open a slot until the next cycle.
  - Empty: no pop, no pulse.
  - Simultaneous push and pop when neither full nor empty: occupancy unchanged, data order preserved.
  - Pointers wrap modulo DEPTH; full/empty use an extra pointer MSB.
- hold_in:
  - Sampled every cycle, no latching.
  - Releasing hold at count 16 drains up to DEPTH writes in consecutive cycles, so a full batch lands within one inter-window gap.
- pending_out: occupancy after the current edge's push/pop (registered), range 0..DEPTH.
- Addresses are passed through unchecked. The datapath ignores unmapped codes 12..15.

Decomposition:
- Package tone_gen_pkg:
  - MASTER_W=10
  - PROC_WINDOW_ID=6'h00
  - address bases: ADDR_INCR=5'h00, ADDR_VOL=5'h04, ADDR_WAVE=5'h08, ADDR_LUT=5'h10
  - typedef reg_wr_t {addr[4:0], data[15:0]}
- One sub-module: reg_wr_fifo (synchronous FIFO of reg_wr_t, DEPTH, full/empty/count).
- Window logic and master counter stay in the top module.

Test Plan:
- Reset: pulse reset_n_in low mid-count (count=300, FIFO holding 2 writes) -> immediately count=0, pending_out=0, reg_valid_out=0, wr_ready_out=1; no queued write is ever issued.
- Window blocking: push addr=5'h01 data=16'h1234 at count 10 -> reg_valid_out stays 0 through count 15; single pulse with addr 01/data 1234 at the edge after count 16.
- Wrap guard: push a write so it is at the FIFO head at count 1022 -> issued at count 1023 edge; a second write arriving at 1023 is held until count 16 of the next frame; never valid while count is 0..15.
- Full/backpressure: DEPTH=4, hold_in=1, push 5 writes (addr 0..4) -> wr_ready_out=0 after the 4th, 5th held by the host; release hold at count 100 -> 4 consecutive pulses addr 0,1,2,3, then the 5th is accepted and issued in order.
- Simultaneous push/pop: FIFO at 2 entries in window, push every cycle while issuing -> pending_out stays 2, output addr sequence matches input order.
- LUT passthrough: write addr=5'h13 data=16'h000A outside the window -> reg_addr_out=5'h13, reg_data_out=16'h000A, one-cycle pulse.
